// File: rtl/inst_fetcher.sv
// Instruction fetcher: IDLE/FETCH/HOLD sequencer with 16/32-bit length decode and predictor redirect.
// Define FETCH_REUSE_EN to issue the upper halfword of a latched word without a new memory request.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  input  logic        need_branch,
  input  logic [31:0] branch_addr,
  input  logic        predict_fail,
  input  logic [31:0] fail_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic        r_discard;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic [31:0] w_pc_next;
  logic        w_discard_next;
  logic        w_mem_req_next;
  logic [31:0] w_mem_addr_next;
  logic [31:0] w_inst_next;
  logic [31:0] w_inst_pc_next;
  logic        w_hs;
  logic        w_len4;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_reuse;
  logic        w_take_reuse;
  logic [15:0] w_reuse_hi;

  assign inst_valid   = (r_state == S_HOLD) && !predict_fail;
  assign w_hs         = inst_valid && dec_ready && rdy_in;
  assign w_len4       = (r_inst[1:0] == 2'b11);
  assign w_target     = need_branch ? branch_addr : (r_pc + (w_len4 ? 32'd4 : 32'd2));
  assign w_accept     = (r_state == S_FETCH) && mem_done && !r_discard && !predict_fail;
  assign w_take_reuse = (r_state == S_HOLD) && w_hs && w_reuse;

`ifdef FETCH_REUSE_EN
  logic [15:0] r_word_hi;
  logic        r_word_ok;

  assign w_reuse    = r_word_ok && (w_target == (r_inst_pc + 32'd2)) && (r_word_hi[1:0] != 2'b11);
  assign w_reuse_hi = r_word_hi;

  // Upper half of the last fetched word, valid until consumed or redirected
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_word_hi <= 16'h0;
      r_word_ok <= 1'b0;
    end else if (rdy_in) begin
      if (predict_fail) begin
        r_word_ok <= 1'b0;
      end else if (w_accept) begin
        r_word_hi <= mem_data[31:16];
        r_word_ok <= 1'b1;
      end else if (w_take_reuse) begin
        r_word_ok <= 1'b0;
      end else begin
        r_word_ok <= r_word_ok;
      end
    end
  end
`else
  assign w_reuse    = 1'b0;
  assign w_reuse_hi = 16'h0;
`endif

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end else begin
      r_state <= r_state;
    end
  end

  // Next-state logic; a discarded or redirected completion passes through IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: begin
        if (mem_done) begin
          w_state_next = (r_discard || predict_fail) ? S_IDLE : S_HOLD;
        end else begin
          w_state_next = S_FETCH;
        end
      end
      S_HOLD: begin
        if (predict_fail) begin
          w_state_next = S_FETCH;
        end else if (w_hs) begin
          w_state_next = w_reuse ? S_HOLD : S_FETCH;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of pc, discard flag and registered outputs
  always_comb begin
    w_pc_next       = r_pc;
    w_discard_next  = r_discard;
    w_inst_next     = r_inst;
    w_inst_pc_next  = r_inst_pc;
    w_mem_req_next  = (w_state_next == S_FETCH);
    w_mem_addr_next = r_mem_addr;

    if (predict_fail) begin
      w_pc_next = fail_addr;
    end else if ((r_state == S_HOLD) && w_hs) begin
      w_pc_next = w_target;
    end else begin
      w_pc_next = r_pc;
    end

    if (r_state == S_FETCH) begin
      if (mem_done) begin
        w_discard_next = 1'b0;
      end else if (predict_fail) begin
        w_discard_next = 1'b1;
      end else begin
        w_discard_next = r_discard;
      end
    end else begin
      w_discard_next = 1'b0;
    end

    // The request address is captured on entry and held while outstanding
    if ((w_state_next == S_FETCH) && (r_state != S_FETCH)) begin
      w_mem_addr_next = w_pc_next;
    end else begin
      w_mem_addr_next = r_mem_addr;
    end

    if (w_accept) begin
      w_inst_next    = (mem_data[1:0] == 2'b11) ? mem_data : {16'h0, mem_data[15:0]};
      w_inst_pc_next = r_mem_addr;
    end else if (w_take_reuse) begin
      w_inst_next    = {16'h0, w_reuse_hi};
      w_inst_pc_next = w_target;
    end else begin
      w_inst_next    = r_inst;
      w_inst_pc_next = r_inst_pc;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pc       <= RESET_PC;
      r_discard  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_inst     <= 32'h0;
      r_inst_pc  <= 32'h0;
    end else if (rdy_in) begin
      r_pc       <= w_pc_next;
      r_discard  <= w_discard_next;
      r_mem_req  <= w_mem_req_next;
      r_mem_addr <= w_mem_addr_next;
      r_inst     <= w_inst_next;
      r_inst_pc  <= w_inst_pc_next;
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign inst_out = r_inst;
  assign inst_pc  = r_inst_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed self-checking bench for inst_fetcher: fetch, length decode, branch, redirect, stall, reset.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        need_branch;
  logic [31:0] branch_addr;
  logic        predict_fail;
  logic [31:0] fail_addr;

  int n_vec = 0;
  int n_err = 0;

  inst_fetcher #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .dec_ready(dec_ready), .need_branch(need_branch), .branch_addr(branch_addr),
    .predict_fail(predict_fail), .fail_addr(fail_addr)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, answer after two more cycles
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_addr"}, mem_addr, addr);
    repeat (2) @(negedge clk_in);
    chk({tag, "_addr_held"}, mem_addr, addr);
    mem_done = 1'b1;
    mem_data = data;
    @(negedge clk_in);
    mem_done = 1'b0;
    mem_data = 32'h0;
  endtask

  task automatic hs();
    dec_ready = 1'b1;
    @(negedge clk_in);
    dec_ready = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; mem_done = 1'b0; mem_data = 32'h0;
    dec_ready = 1'b0; need_branch = 1'b0; branch_addr = 32'h0;
    predict_fail = 1'b0; fail_addr = 32'h0;
    repeat (2) @(negedge clk_in);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    rst_in = 1'b0;

    // First fetch from RESET_PC, 4-byte instruction
    fetch("f0", 32'h0, 32'h00500093);
    chk("f0_valid", {31'd0, inst_valid}, 32'd1);
    chk("f0_inst", inst_out, 32'h00500093);
    chk("f0_pc", inst_pc, 32'h0);
    chk("f0_req_low", {31'd0, mem_req}, 32'd0);
    @(negedge clk_in);
    chk("f0_hold_pc", inst_pc, 32'h0);
    chk("f0_hold_inst", inst_out, 32'h00500093);
    hs();
    fetch("f4", 32'h4, 32'h00108113);
    chk("f4_inst", inst_out, 32'h00108113);

    // Stall: rdy low with decoder ready freezes everything
    rdy_in = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_pc", inst_pc, 32'h4);
      chk("stall_inst", inst_out, 32'h00108113);
      chk("stall_req", {31'd0, mem_req}, 32'd0);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    dec_ready = 1'b0;
    chk("resume_req", {31'd0, mem_req}, 32'd1);
    chk("resume_addr", mem_addr, 32'h8);

    // Compressed instruction: upper half zeroed, next pc = pc+2
    fetch("f8", 32'h8, 32'h45014501);
    chk("f8_inst", inst_out, 32'h00004501);
    chk("f8_pc", inst_pc, 32'h8);
    hs();
`ifdef FETCH_REUSE_EN
    chk("reuse_noreq", {31'd0, mem_req}, 32'd0);
    chk("reuse_valid", {31'd0, inst_valid}, 32'd1);
`else
    fetch("fA", 32'hA, 32'h00004501);
`endif
    chk("fA_inst", inst_out, 32'h00004501);
    chk("fA_pc", inst_pc, 32'hA);

    // Taken branches
    need_branch = 1'b1; branch_addr = 32'h10;
    hs();
    need_branch = 1'b0;
    fetch("f10", 32'h10, 32'h00000013);
    chk("f10_pc", inst_pc, 32'h10);
    need_branch = 1'b1; branch_addr = 32'h40;
    hs();
    need_branch = 1'b0;
    fetch("f40", 32'h40, 32'h00000013);
    chk("f40_pc", inst_pc, 32'h40);

    // Redirect in HOLD beats a simultaneous handshake
    predict_fail = 1'b1; fail_addr = 32'h20; dec_ready = 1'b1;
    #1;
    chk("pf_hold_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk_in);
    predict_fail = 1'b0; dec_ready = 1'b0;
    chk("pf_hold_req", {31'd0, mem_req}, 32'd1);
    chk("pf_hold_addr", mem_addr, 32'h20);

    // Two redirects during FETCH; the in-flight data must be dropped
    predict_fail = 1'b1; fail_addr = 32'h90;
    @(negedge clk_in);
    fail_addr = 32'h80;
    @(negedge clk_in);
    predict_fail = 1'b0;
    chk("disc_addr_held", mem_addr, 32'h20);
    chk("disc_req_held", {31'd0, mem_req}, 32'd1);
    mem_done = 1'b1; mem_data = 32'hDEADBEEF;
    @(negedge clk_in);
    mem_done = 1'b0; mem_data = 32'h0;
    chk("disc_gap_req", {31'd0, mem_req}, 32'd0);
    chk("disc_gap_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk_in);
    chk("disc_valid", {31'd0, inst_valid}, 32'd0);
    fetch("f80", 32'h80, 32'h00000513);
    chk("f80_inst", inst_out, 32'h00000513);
    chk("f80_pc", inst_pc, 32'h80);

    // Reset mid-FETCH (with rdy low) and a late completion
    hs();
    chk("f84_addr", mem_addr, 32'h84);
    rst_in = 1'b1; rdy_in = 1'b0;
    @(negedge clk_in);
    chk("rst2_req", {31'd0, mem_req}, 32'd0);
    chk("rst2_addr", mem_addr, 32'h0);
    chk("rst2_pc", inst_pc, 32'h0);
    chk("rst2_inst", inst_out, 32'h0);
    rst_in = 1'b0; rdy_in = 1'b1;
    mem_done = 1'b1; mem_data = 32'h11111111;
    @(negedge clk_in);
    mem_done = 1'b0; mem_data = 32'h0;
    chk("late_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_req", {31'd0, mem_req}, 32'd1);
    chk("late_addr", mem_addr, 32'h0);
    @(negedge clk_in);
    chk("late_inst", inst_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
